// File: rtl/uart_tx.sv
// UART transmitter: TX FIFO, baud divider and start/data/stop serializer on one line.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).

module uart_tx #(
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int WIDTH          = 8,
    parameter int SAMPLING_TICKS = 16,
    parameter int STOP_BITS      = 1,
    parameter int DEPTH          = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD     = 1'b0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d_in,
    output logic             tx,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             tx_done,
    output logic             overflow
);

    localparam int DIV_RAW    = CLOCK_FREQ / (BAUD_RATE * SAMPLING_TICKS);
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STOP_TICKS = STOP_BITS * SAMPLING_TICKS;
    localparam int TICK_W     = $clog2(STOP_TICKS + 1);
    localparam int BIT_W      = $clog2(WIDTH + 1);
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int CNT_W      = ADDR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic              baud_tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WIDTH-1:0]  shift;
    logic              tx_next;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != S_IDLE);
    assign push  = wr_en && !full;
    assign pop   = (state == S_IDLE) && !empty;

    // NOTE: storage has no reset; only pointers and count define FIFO contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_in;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Divider is parked at zero while idle so every frame starts on a full bit period.
    assign baud_tick = (state != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || baud_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shift    <= mem[rd_ptr];
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^mem[rd_ptr]) ^ PARITY_ODD;
`endif
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_W'(SAMPLING_TICKS - 1)) begin
                            tick_cnt <= '0;
                            state    <= S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_W'(SAMPLING_TICKS - 1)) begin
                            tick_cnt <= '0;
                            shift    <= {1'b0, shift[WIDTH-1:1]};
                            if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= S_PARITY;
`else
                                state   <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_W'(SAMPLING_TICKS - 1)) begin
                            tick_cnt <= '0;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_W'(STOP_TICKS - 1)) begin
                            tick_cnt <= '0;
                            tx_done  <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line level follows the state one clock later through a flop, so it never glitches.
    always_comb begin
        // NOTE: default first so every path assigns tx_next and no latch is inferred.
        tx_next = 1'b1;
        case (state)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = parity_bit;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= 1'b1;
        end else begin
            tx <= tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 160-clock bits, one STOP_BITS=1 instance and one STOP_BITS=2 instance.
// Each frame is checked clock by clock against a bit-pattern model built from the written byte.

module tb_uart_tx;

    localparam int CF      = 1_600_000;
    localparam int BR      = 10_000;
    localparam int BIT_CLK = 160;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, wr_en2;
    logic [7:0] d_in, d_in2;
    logic       tx, full, empty, busy, tx_done, overflow;
    logic       tx2, full2, empty2, busy2, tx_done2, overflow2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .WIDTH(8), .SAMPLING_TICKS(16),
              .STOP_BITS(1), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .d_in(d_in), .tx(tx), .full(full),
        .empty(empty), .busy(busy), .tx_done(tx_done), .overflow(overflow)
    );

    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .WIDTH(8), .SAMPLING_TICKS(16),
              .STOP_BITS(2), .DEPTH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .d_in(d_in2), .tx(tx2), .full(full2),
        .empty(empty2), .busy(busy2), .tx_done(tx_done2), .overflow(overflow2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] data, input int b);
        if (b == 0)            return 1'b0;
        if (b <= 8)            return data[b-1];
        if (PAR == 1 && b == 9) return ^data;
        return 1'b1;
    endfunction

    // Clocks until tx reads low, starting from the current sample point.
    task automatic wait_fall(input bit sel, input int exp_gap, input string name);
        int n;
        n = 0;
        while ((sel ? tx2 : tx) !== 1'b0 && n < 4000) begin
            step();
            n++;
        end
        checks++;
        if (n !== exp_gap) begin
            failures++;
            $display("FAIL %s start delay: got %0d clocks, expected %0d", name, n, exp_gap);
        end
    endtask

    // Called on the first clock of the start bit; leaves on the first clock after the frame.
    task automatic capture_frame(input bit sel, input logic [7:0] data, input int stop_bits,
                                 input string name);
        int   nbits, fc, done_cnt, done_at;
        logic exp_bit, now, got;
        bit   bad;
        nbits    = 1 + 8 + PAR + stop_bits;
        fc       = nbits * BIT_CLK;
        done_cnt = 0;
        done_at  = -1;
        for (int b = 0; b < nbits; b++) begin
            exp_bit = frame_bit(data, b);
            got     = exp_bit;
            bad     = 1'b0;
            for (int c = 0; c < BIT_CLK; c++) begin
                now = sel ? tx2 : tx;
                if (now !== exp_bit) begin
                    bad = 1'b1;
                    got = now;
                end
                if ((sel ? tx_done2 : tx_done) === 1'b1) begin
                    done_cnt++;
                    done_at = b * BIT_CLK + c + 1;
                end
                step();
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s bit%0d: tx got %b, expected %b on all %0d clocks",
                         name, b, got, exp_bit, BIT_CLK);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== fc) begin
            failures++;
            $display("FAIL %s tx_done: %0d pulses, last at clock %0d, expected 1 at clock %0d",
                     name, done_cnt, done_at, fc);
        end
    endtask

    task automatic check_idle(input int n, input string name);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: line left idle (tx=%b busy=%b), expected tx=1 busy=0", name, tx, busy);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
        d_in   = '0;
        d_in2  = '0;
        repeat (3) step();
        checks++;
        if ({tx, empty, full, busy, tx_done, overflow} !== 6'b110000) begin
            failures++;
            $display("FAIL reset dut: {tx,empty,full,busy,tx_done,overflow} got %b expected 110000",
                     {tx, empty, full, busy, tx_done, overflow});
        end
        checks++;
        if ({tx2, empty2, full2, busy2, tx_done2, overflow2} !== 6'b110000) begin
            failures++;
            $display("FAIL reset dut2: flags got %b expected 110000",
                     {tx2, empty2, full2, busy2, tx_done2, overflow2});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_byte();
        wr_en = 1'b1;
        d_in  = 8'hA5;
        step();
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single after write: empty=%b busy=%b expected empty=0 busy=0", empty, busy);
        end
        wait_fall(1'b0, 2, "single");
        capture_frame(1'b0, 8'hA5, 1, "single A5");
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL single end: busy=%b empty=%b tx=%b expected 0 1 1", busy, empty, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = bytes[i];
            step();
        end
        wr_en = 1'b0;
        // Already two clocks past the first write, so the start bit is on the line now.
        wait_fall(1'b0, 0, "burst frame0");
        capture_frame(1'b0, bytes[0], 1, "burst 00");
        wait_fall(1'b0, 1, "burst gap1");
        capture_frame(1'b0, bytes[1], 1, "burst FF");
        wait_fall(1'b0, 1, "burst gap2");
        capture_frame(1'b0, bytes[2], 1, "burst 55");
        checks++;
        if (empty !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL burst end: empty=%b busy=%b expected 1 0", empty, busy);
        end
    endtask

    task automatic test_full_overflow();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr_en = 1'b1;
                    d_in  = 8'(8'h10 + i);
                    step();
                    if (i == 15) begin
                        checks++;
                        if (full !== 1'b0) begin
                            failures++;
                            $display("FAIL full early: full=%b after 16 writes, expected 0", full);
                        end
                    end
                    if (i == 16) begin
                        checks++;
                        if (full !== 1'b1 || overflow !== 1'b0) begin
                            failures++;
                            $display("FAIL full set: full=%b overflow=%b expected 1 0", full, overflow);
                        end
                    end
                    if (i == 17) begin
                        checks++;
                        if (overflow !== 1'b1) begin
                            failures++;
                            $display("FAIL overflow pulse: got %b expected 1", overflow);
                        end
                    end
                end
                wr_en = 1'b0;
                step();
                checks++;
                if (overflow !== 1'b0 || full !== 1'b1) begin
                    failures++;
                    $display("FAIL overflow end: overflow=%b full=%b expected 0 1", overflow, full);
                end
            end
            begin
                step();
                wait_fall(1'b0, 2, "fill frame0");
                for (int i = 0; i < 17; i++) begin
                    capture_frame(1'b0, 8'(8'h10 + i), 1, $sformatf("fill frame%0d", i));
                    if (i < 16) wait_fall(1'b0, 1, $sformatf("fill gap%0d", i + 1));
                end
            end
        join
        check_idle(400, "fill no 18th frame");
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL fill end: empty=%b full=%b expected 1 0", empty, full);
        end
    endtask

    task automatic test_reset_mid_frame();
        wr_en = 1'b1;
        d_in  = 8'h3C;
        step();
        d_in  = 8'h77;
        step();
        wr_en = 1'b0;
        wait_fall(1'b0, 1, "rst frame");
        repeat (4 * BIT_CLK + 80) step();
        checks++;
        if (busy !== 1'b1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL rst pre: busy=%b empty=%b expected 1 0", busy, empty);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, empty, full, tx_done, overflow} !== 6'b101000) begin
            failures++;
            $display("FAIL rst async: {tx,busy,empty,full,tx_done,overflow} got %b expected 101000",
                     {tx, busy, empty, full, tx_done, overflow});
        end
        repeat (2) step();
        rst_n = 1'b1;
        check_idle(400, "rst after release");
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL rst empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_two_stop_bits();
        wr_en2 = 1'b1;
        d_in2  = 8'h81;
        step();
        wr_en2 = 1'b0;
        wait_fall(1'b1, 2, "stop2");
        capture_frame(1'b1, 8'h81, 2, "stop2 81");
        checks++;
        if (busy2 !== 1'b0 || empty2 !== 1'b1 || tx2 !== 1'b1) begin
            failures++;
            $display("FAIL stop2 end: busy=%b empty=%b tx=%b expected 0 1 1", busy2, empty2, tx2);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full_overflow();
        test_reset_mid_frame();
        test_two_stop_bits();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
